ifu_fetch: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Consumes the stall/flush controls from the pipeline hazard monitor (IF_reg_inst_enable, IF_reg_inst_flush) and the redirect target.
- Issues one-at-a-time fetch requests over a valid/ready instruction-memory port.
- Presents IF_ID_reg_inst_valid / inst / PC to decode, holding a returned instruction while decode stalls.

---
 rtl/ifu_fetch.sv | 141 ++++++++++++++
 tb/tb_ifu_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction-fetch stage with one outstanding request and IF/ID
//            pipeline register; hold buffer covers decode stalls.
// Revision : 1.0
// ============================================================================
module ifu_fetch #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             IF_reg_inst_enable,
   input  logic             IF_reg_inst_flush,
   input  logic [XLEN-1:0]  jump_addr,
   output logic             ifu_req_valid,
   input  logic             ifu_req_ready,
   output logic [XLEN-1:0]  ifu_req_addr,
   input  logic             ifu_rsp_valid,
   input  logic [XLEN-1:0]  ifu_rsp_inst,
   output logic             IF_ID_reg_inst_valid,
   output logic [XLEN-1:0]  IF_ID_reg_inst,
   output logic [XLEN-1:0]  IF_ID_reg_PC
);

   localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_fetch_pc;
   logic [XLEN-1:0]   w_fetch_pc_nxt;
   logic              r_drop;
   logic              w_drop_nxt;
   logic [XLEN-1:0]   r_hold_inst;
   logic              w_capture;
   logic              w_load;
   logic [XLEN-1:0]   w_load_inst;
   logic              r_if_id_valid;
   logic [XLEN-1:0]   r_if_id_inst;
   logic [XLEN-1:0]   r_if_id_pc;

   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_drop_nxt     = r_drop;
      w_capture      = 1'b0;
      w_load         = 1'b0;
      w_load_inst    = r_hold_inst;

      case (r_state)
         S_REQ: begin
            if (ifu_req_ready) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (ifu_rsp_valid) begin
               if (r_drop) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = S_REQ;
               end else if (IF_reg_inst_enable) begin
                  w_load         = 1'b1;
                  w_load_inst    = ifu_rsp_inst;
                  w_fetch_pc_nxt = r_fetch_pc + c_pc_step;
                  w_state_nxt    = S_REQ;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (IF_reg_inst_enable) begin
               w_load         = 1'b1;
               w_fetch_pc_nxt = r_fetch_pc + c_pc_step;
               w_state_nxt    = S_REQ;
            end
         end
         default: w_state_nxt = S_REQ;
      endcase

      // Redirect overrides everything; an already-accepted request must still
      // have its response swallowed, hence the drop marker.
      if (IF_reg_inst_flush) begin
         w_load         = 1'b0;
         w_capture      = 1'b0;
         w_fetch_pc_nxt = jump_addr;
         case (r_state)
            S_REQ: begin
               w_drop_nxt  = ifu_req_ready;
               w_state_nxt = ifu_req_ready ? S_WAIT : S_REQ;
            end
            S_WAIT: begin
               w_drop_nxt  = !ifu_rsp_valid;
               w_state_nxt = ifu_rsp_valid ? S_REQ : S_WAIT;
            end
            default: begin
               w_drop_nxt  = 1'b0;
               w_state_nxt = S_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_REQ;
         r_fetch_pc    <= RESET_PC;
         r_drop        <= 1'b0;
         r_hold_inst   <= '0;
         r_if_id_valid <= 1'b0;
         r_if_id_inst  <= '0;
         r_if_id_pc    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_drop     <= w_drop_nxt;
         if (w_capture) r_hold_inst <= ifu_rsp_inst;
         if (w_load) begin
            r_if_id_valid <= 1'b1;
            r_if_id_inst  <= w_load_inst;
            r_if_id_pc    <= r_fetch_pc;
         end else if (IF_reg_inst_flush || IF_reg_inst_enable) begin
            r_if_id_valid <= 1'b0;
         end
      end
   end

   assign ifu_req_valid        = (r_state == S_REQ);
   assign ifu_req_addr         = r_fetch_pc;
   assign IF_ID_reg_inst_valid = r_if_id_valid;
   assign IF_ID_reg_inst       = r_if_id_inst;
   assign IF_ID_reg_PC         = r_if_id_pc;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Randomized bench for ifu_fetch against a transaction-level model
//            of in-flight requests, buffered instructions and IF/ID contents.
// Revision : 1.0
// ============================================================================
module tb_ifu_fetch;

   localparam logic [31:0] c_reset_pc = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        IF_reg_inst_enable;
   logic        IF_reg_inst_flush;
   logic [31:0] jump_addr;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_req_addr;
   logic        ifu_rsp_valid;
   logic [31:0] ifu_rsp_inst;
   logic        IF_ID_reg_inst_valid;
   logic [31:0] IF_ID_reg_inst;
   logic [31:0] IF_ID_reg_PC;

   ifu_fetch #(.XLEN(32), .RESET_PC(c_reset_pc)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .IF_reg_inst_enable   (IF_reg_inst_enable),
      .IF_reg_inst_flush    (IF_reg_inst_flush),
      .jump_addr            (jump_addr),
      .ifu_req_valid        (ifu_req_valid),
      .ifu_req_ready        (ifu_req_ready),
      .ifu_req_addr         (ifu_req_addr),
      .ifu_rsp_valid        (ifu_rsp_valid),
      .ifu_rsp_inst         (ifu_rsp_inst),
      .IF_ID_reg_inst_valid (IF_ID_reg_inst_valid),
      .IF_ID_reg_inst       (IF_ID_reg_inst),
      .IF_ID_reg_PC         (IF_ID_reg_PC)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
      bit          live;
   } item_t;

   // Model: requests the memory owes us, instructions waiting for decode,
   // the architectural next-fetch address and the IF/ID contents.
   item_t       inflight[$];
   item_t       held[$];
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_pc_out;

   bit          rsp_pend;
   int          rsp_lat;
   logic [31:0] rsp_addr;

   int p_ready, p_en, p_flush, max_lat;
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_inst(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16]};
   endfunction

   function automatic logic [31:0] pick_jump();
      case ($urandom_range(0, 3))
         0:       return 32'h8000_0100;
         1:       return 32'hFFFF_FFFC;
         2:       return $urandom;
         default: return c_reset_pc + 32'($urandom_range(0, 63) * 4);
      endcase
   endfunction

   task automatic model_reset();
      inflight.delete();
      held.delete();
      m_pc     = c_reset_pc;
      m_valid  = 1'b0;
      m_inst   = '0;
      m_pc_out = '0;
   endtask

   task automatic run_cycle(input bit do_rst, input bit do_flush,
                            input logic [31:0] jaddr, input bit no_ready);
      bit          exp_req;
      bit          hs;
      bit          got;
      item_t       it;
      logic [31:0] d_addr;
      logic [31:0] d_inst;
      @(negedge clk);
      exp_req = (inflight.size() == 0) && (held.size() == 0);
      check("req_valid", 32'(ifu_req_valid), 32'(exp_req));
      if (exp_req) check("req_addr", ifu_req_addr, m_pc);
      check("ifid_valid", 32'(IF_ID_reg_inst_valid), 32'(m_valid));
      if (m_valid) begin
         check("ifid_inst", IF_ID_reg_inst, m_inst);
         check("ifid_pc", IF_ID_reg_PC, m_pc_out);
      end

      rst                = do_rst;
      IF_reg_inst_flush  = !do_rst && (do_flush || ($urandom_range(0, 99) < p_flush));
      jump_addr          = do_flush ? jaddr : pick_jump();
      IF_reg_inst_enable = ($urandom_range(0, 99) < p_en);
      ifu_req_ready      = !no_ready && ($urandom_range(0, 99) < p_ready);
      ifu_rsp_valid      = 1'b0;
      ifu_rsp_inst       = $urandom;
      if (rsp_pend && do_rst) begin
         rsp_lat = 0;
      end else if (rsp_pend) begin
         if (rsp_lat == 0) begin
            ifu_rsp_valid = 1'b1;
            ifu_rsp_inst  = mem_inst(rsp_addr);
            rsp_pend      = 1'b0;
         end else begin
            rsp_lat--;
         end
      end

      if (do_rst) begin
         model_reset();
      end else begin
         hs  = exp_req && ifu_req_ready;
         got = 1'b0;
         d_addr = '0;
         d_inst = '0;
         if (ifu_rsp_valid && inflight.size() > 0) begin
            it = inflight.pop_front();
            if (it.live && !IF_reg_inst_flush) begin
               if (IF_reg_inst_enable) begin
                  got = 1'b1; d_addr = it.addr; d_inst = ifu_rsp_inst;
               end else begin
                  it.inst = ifu_rsp_inst;
                  held.push_back(it);
               end
            end
         end else if (held.size() > 0 && IF_reg_inst_enable && !IF_reg_inst_flush) begin
            it = held.pop_front();
            got = 1'b1; d_addr = it.addr; d_inst = it.inst;
         end
         if (hs) begin
            rsp_pend = 1'b1;
            rsp_lat  = $urandom_range(0, max_lat - 1);
            rsp_addr = m_pc;
            inflight.push_back('{addr: m_pc, inst: 32'h0, live: !IF_reg_inst_flush});
         end
         if (IF_reg_inst_flush) begin
            foreach (inflight[i]) inflight[i].live = 1'b0;
            held.delete();
            m_pc    = jump_addr;
            m_valid = 1'b0;
         end else if (got) begin
            m_valid  = 1'b1;
            m_inst   = d_inst;
            m_pc_out = d_addr;
            m_pc     = d_addr + 32'd4;
         end else if (IF_reg_inst_enable) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic set_knobs(input int rdy, input int en, input int fl, input int lat);
      p_ready = rdy; p_en = en; p_flush = fl; max_lat = lat;
   endtask

   initial begin
      bit found;
      rst = 1'b1; IF_reg_inst_enable = 1'b0; IF_reg_inst_flush = 1'b0;
      jump_addr = '0; ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = '0;
      rsp_pend = 1'b0; rsp_lat = 0; rsp_addr = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", 32'(ifu_req_valid), 32'd1);
      check("rst_req_addr", ifu_req_addr, c_reset_pc);
      check("rst_ifid_valid", 32'(IF_ID_reg_inst_valid), 32'd0);
      check("rst_ifid_inst", IF_ID_reg_inst, 32'd0);
      check("rst_ifid_pc", IF_ID_reg_PC, 32'd0);

      set_knobs(100, 100, 0, 1);
      repeat (16) run_cycle(0, 0, '0, 0);
      set_knobs(80, 30, 0, 3);
      repeat (300) run_cycle(0, 0, '0, 0);
      set_knobs(60, 70, 15, 3);
      repeat (600) run_cycle(0, 0, '0, 0);
      set_knobs(20, 60, 8, 2);
      repeat (300) run_cycle(0, 0, '0, 0);

      set_knobs(100, 100, 0, 2);
      run_cycle(0, 1, 32'hFFFF_FFFC, 0);
      repeat (20) run_cycle(0, 0, '0, 0);

      for (int r = 0; r < 5; r++) begin
         found = 1'b0;
         for (int k = 0; k < 50 && !found; k++) begin
            run_cycle(0, 0, '0, 0);
            found = (inflight.size() > 0) && rsp_pend;
         end
         check("reach_wait", 32'(found), 32'd1);
         if (found) begin
            run_cycle(1, 0, '0, 0);
            run_cycle(0, 0, '0, 1);
         end
         set_knobs(70, 60, 10, 3);
         repeat (30) run_cycle(0, 0, '0, 0);
      end

      run_cycle(0, 0, '0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
